lut_wvf_loader: RTL



---
 rtl/lut_wvf_pkg.sv | 26 ++
 rtl/lut_wvf_bank.sv | 41 ++++
 rtl/lut_wvf_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lut_wvf_pkg.sv
// ----------------------------------------------------------------------------
// lut_wvf_pkg
// Shared definitions for the quarter-wave LUT waveform generator and its
// double-buffered table loader.
//   - state encoding of the loader FSM
//   - entry_width(): stored entry width, one bit narrower than the generator
//     output because only the quarter-wave magnitude is kept
// No ports (package).
// ----------------------------------------------------------------------------
package lut_wvf_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        PENDING = ST_PENDING
    } loader_state_t;

    function automatic int entry_width(input int bit_width);
        return bit_width - 1;
    endfunction

endpackage

// File: rtl/lut_wvf_bank.sv
// ----------------------------------------------------------------------------
// lut_wvf_bank
// Register array of DEPTH entries, WIDTH bits each, exposed as one flat bus.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all)
//   wr_en/wr_addr/wr_data  single-entry write port
//   copy_en/copy_data   whole-bank load in a single edge (wins over wr_en)
//   flat                entry i at [i*WIDTH +: WIDTH]
// ----------------------------------------------------------------------------
module lut_wvf_bank #(
    parameter  int DEPTH  = 32,
    parameter  int WIDTH  = 15,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   copy_en,
    input  logic [DEPTH*WIDTH-1:0] copy_data,
    output logic [DEPTH*WIDTH-1:0] flat
);

    logic [DEPTH*WIDTH-1:0] bank_q;

    // Storage. A whole-bank copy replaces every entry at once, so a reader of
    // the flat bus never sees a half-updated table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (copy_en) begin
            bank_q <= copy_data;
        end else if (wr_en) begin
            bank_q[wr_addr*WIDTH +: WIDTH] <= wr_data;
        end
    end

    assign flat = bank_q;

endmodule

// File: rtl/lut_wvf_loader.sv
// ----------------------------------------------------------------------------
// lut_wvf_loader
// Double-buffered write-side loader for the quarter-wave LUT generator.
// Entries stream into a shadow bank; the shadow is copied into the active
// bank (driven on LUT_ROM) only at a waveform period boundary, or at once
// when the generator is disabled.
// Ports:
//   CLK_SYS, nRST        clock, asynchronous active-low reset
//   START                begin a new load (restarts an unfinished one)
//   DATA_IN/VALID/READY  entry stream, one entry per cycle
//   GEN_EN, GEN_LUT_END  generator enable and end-of-period strobe
//   LUT_ROM              active bank, flat
//   WR_PTR               next entry index to be written
//   BUSY                 loading or waiting for the swap
//   LOAD_DONE            one-cycle pulse, active bank updated
//   ERR_ABORT            one-cycle pulse, load restarted before completion
// ----------------------------------------------------------------------------
module lut_wvf_loader
    import lut_wvf_pkg::*;
#(
    parameter  int LUT_WIDTH = 32,
    parameter  int BIT_WIDTH = 16,
    localparam int ENTRY_W   = entry_width(BIT_WIDTH),
    localparam int PTR_W     = (LUT_WIDTH > 1) ? $clog2(LUT_WIDTH) : 1
) (
    input  logic                         CLK_SYS,
    input  logic                         nRST,
    input  logic                         START,
    input  logic [ENTRY_W-1:0]           DATA_IN,
    input  logic                         DATA_VALID,
    output logic                         DATA_READY,
    input  logic                         GEN_EN,
    input  logic                         GEN_LUT_END,
    output logic [ENTRY_W*LUT_WIDTH-1:0] LUT_ROM,
    output logic [PTR_W-1:0]             WR_PTR,
    output logic                         BUSY,
    output logic                         LOAD_DONE,
    output logic                         ERR_ABORT
);

    loader_state_t              state_q;
    loader_state_t              state_d;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           wr_ptr_d;
    logic                       load_done_q;
    logic                       err_abort_q;
    logic                       data_ready;
    logic                       transfer;
    logic                       swap;
    logic                       abort;
    logic                       last_entry;
    logic [ENTRY_W*LUT_WIDTH-1:0] shadow_flat;

    assign last_entry = (wr_ptr_q == PTR_W'(LUT_WIDTH - 1));

    // Only a START that interrupts a load in flight counts as an abort.
    assign abort = START && (state_q != IDLE);

    // Next-state and handshake decode. START outranks everything: it drops
    // READY (so no entry is taken) and blocks a same-cycle swap. The swap is
    // only evaluated while PENDING, so a period end coinciding with the last
    // transfer is deliberately missed.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        data_ready = 1'b0;
        transfer   = 1'b0;
        swap       = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            LOAD: begin
                if (START) begin
                    wr_ptr_d = '0;
                end else begin
                    data_ready = 1'b1;
                    if (DATA_VALID) begin
                        transfer = 1'b1;
                        if (last_entry) begin
                            wr_ptr_d = '0;
                            state_d  = PENDING;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
            end
            PENDING: begin
                if (START) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end else if (GEN_LUT_END || !GEN_EN) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_ptr_d = '0;
            end
        endcase
    end

    // State, write pointer and the registered status pulses. LOAD_DONE rises
    // on the same edge that copies the shadow into the active bank.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            load_done_q <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            load_done_q <= swap;
            err_abort_q <= abort;
        end
    end

    lut_wvf_bank #(
        .DEPTH (LUT_WIDTH),
        .WIDTH (ENTRY_W)
    ) u_shadow (
        .clk       (CLK_SYS),
        .rst_n     (nRST),
        .wr_en     (transfer),
        .wr_addr   (wr_ptr_q),
        .wr_data   (DATA_IN),
        .copy_en   (1'b0),
        .copy_data ('0),
        .flat      (shadow_flat)
    );

    lut_wvf_bank #(
        .DEPTH (LUT_WIDTH),
        .WIDTH (ENTRY_W)
    ) u_active (
        .clk       (CLK_SYS),
        .rst_n     (nRST),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   ('0),
        .copy_en   (swap),
        .copy_data (shadow_flat),
        .flat      (LUT_ROM)
    );

    assign DATA_READY = data_ready;
    assign WR_PTR     = wr_ptr_q;
    assign BUSY       = (state_q == LOAD) || (state_q == PENDING);
    assign LOAD_DONE  = load_done_q;
    assign ERR_ABORT  = err_abort_q;

endmodule
